// File: rtl/cache_refill_ctrl.sv
// Miss-handling refill controller: takes one miss, obtains a victim way from the
// replacement policy, bursts the line in from memory and writes data and tag arrays.
module cache_refill_ctrl #(
    parameter int WAY_COUNT      = 2,
    parameter int SET_COUNT      = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    localparam int WRD_W = $clog2(WORDS_PER_LINE),
    localparam int OFF_W = WRD_W + $clog2(DATA_WIDTH / 8),
    localparam int SET_W = $clog2(SET_COUNT),
    localparam int WAY_W = $clog2(WAY_COUNT),
    localparam int TAG_W = ADDR_WIDTH - SET_W - OFF_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic [SET_W-1:0]      rp_set,
    input  logic [WAY_W-1:0]      rp_way,
    input  logic                  rp_ready,
    output logic                  rp_taken,
    output logic                  rp_written,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  arr_we,
    output logic [SET_W-1:0]      arr_set,
    output logic [WAY_W-1:0]      arr_way,
    output logic [WRD_W-1:0]      arr_word,
    output logic [DATA_WIDTH-1:0] arr_wdata,
    output logic                  tag_we,
    output logic [TAG_W-1:0]      tag_wdata,
    output logic                  refill_done,
    output logic                  protocol_error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_REQ    = 3'd2,
        S_FILL   = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [TAG_W-1:0]   r_tag;
    logic [SET_W-1:0]   r_set;
    logic [WAY_W-1:0]   r_way;
    logic [WRD_W-1:0]   r_beat;
    logic               r_perr;
    logic               w_last_beat;
    logic               w_stray_beat;
    logic               w_unused_off;

    // Byte/word offset of the miss address is irrelevant: the whole line is fetched.
    assign w_unused_off = ^miss_addr[OFF_W-1:0];

    assign w_last_beat  = (r_beat == WRD_W'(WORDS_PER_LINE - 1));
    assign w_stray_beat = mem_rsp_valid &&
                          (r_state == S_IDLE || r_state == S_SELECT || r_state == S_REQ);

    assign rp_set         = r_set;
    assign arr_set        = r_set;
    assign arr_way        = r_way;
    assign arr_word       = r_beat;
    assign arr_wdata      = mem_rsp_data;
    assign tag_wdata      = r_tag;
    assign mem_req_addr   = {r_tag, r_set, {OFF_W{1'b0}}};
    assign protocol_error = r_perr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        miss_ready    = 1'b0;
        rp_taken      = 1'b0;
        rp_written    = 1'b0;
        mem_req_valid = 1'b0;
        arr_we        = 1'b0;
        tag_we        = 1'b0;
        refill_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) w_next = S_SELECT;
            end
            S_SELECT: begin
                if (rp_ready) begin
                    rp_taken = 1'b1;
                    w_next   = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_next = S_FILL;
            end
            S_FILL: begin
                arr_we = mem_rsp_valid;
                if (mem_rsp_valid && w_last_beat) w_next = S_COMMIT;
            end
            S_COMMIT: begin
                tag_we      = 1'b1;
                rp_written  = 1'b1;
                refill_done = 1'b1;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request context latches; beat counter wraps to zero on the last beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tag  <= '0;
            r_set  <= '0;
            r_way  <= '0;
            r_beat <= '0;
            r_perr <= 1'b0;
        end else begin
            if (r_state == S_IDLE && miss_valid) begin
                r_tag <= miss_addr[ADDR_WIDTH-1 -: TAG_W];
                r_set <= miss_addr[OFF_W +: SET_W];
            end
            if (r_state == S_SELECT && rp_ready) r_way <= rp_way;
            if (r_state == S_REQ && mem_req_ready) r_beat <= '0;
            if (arr_we) r_beat <= r_beat + 1'b1;
            if (w_stray_beat) r_perr <= 1'b1;
        end
    end

endmodule
